cpu_exec_stage: RTL and testbench
=================================

Name: cpu_exec_stage

Overview:
- Decode/execute/write-back stage directly downstream of the instruction-fetch stage. Consumes the fetched instruction word (ir) and its word-index pc.
- Holds the 32 x 64-bit general-purpose register file (x0-x31).
- Executes a small RV64I subset plus a board HALT opcode.
- Drives a PC-redirect pulse back to fetch for taken branches and jumps.

Parameters:
- XLEN, 64, register and datapath width.
- PC_W, 32, width of the word-index program counter.

Ports:
- clock_1hz  input  1  stage clock (slow board clock)
- reset_n  input  1  asynchronous, active-low reset
- if_valid  input  1  fetch presents a valid instruction
- if_ir  input  32  instruction word
- if_pc  input  PC_W  word index of if_ir
- ex_ready  output  1  stage accepts an instruction this cycle
- redirect_valid  output  1  one-cycle pulse: fetch must load redirect_pc and discard its in-flight word
- redirect_pc  output  PC_W  new word-index pc
- illegal  output  1  one-cycle pulse: unsupported opcode retired as NOP
- halted  output  1  sticky: HALT executed
- dbg_sel  input  5  register-file debug read index
- dbg_data  output  XLEN  combinational read of x[dbg_sel]; x0 always reads 0

Behaviour:
- Reset (async, reset_n low):
  - State goes to IDLE.
  - redirect_valid=0, redirect_pc=0, illegal=0, halted=0.
  - All registers cleared to 0.
  - ex_ready=1 as soon as reset releases.
- FSM states: IDLE, EXEC, FLUSH, HALT.
- ex_ready=1 only in IDLE.
- IDLE:
  - If if_valid=1, latch if_ir/if_pc on the edge and go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (one cycle): decode the latched ir, write rd on the exiting edge, then:
  - taken branch or JAL: set redirect_valid=1 and redirect_pc, go to FLUSH;
  - HALT: set halted=1, go to HALT;
  - otherwise: go to IDLE.
- FLUSH (one cycle): redirect_valid=1, ex_ready=0, then go to IDLE. redirect_valid is therefore high for exactly one cycle.
- HALT: ex_ready=0 and halted=1 until reset; if_valid is ignored.
- Throughput and latency:
  - One instruction per 2 cycles when no redirect; 3 cycles for a redirect.
  - Register write becomes visible on dbg_data 2 edges after acceptance.
- Decode (opcode = ir[6:0]):
  - 0110111 LUI: rd = sext64(ir[31:12]<<12).
  - 0010011 with funct3=000 ADDI: rd = rs1 + sext64(imm_i).
  - 0110011 ADD/SUB, funct3=000: funct7=0000000 gives ADD, funct7=0100000 gives SUB. Result is rs1 +/- rs2, mod 2^64.
  - 1100011 with funct3=000 BEQ, funct3=001 BNE: branch is taken when the condition holds.
  - 1101111 JAL: rd = zero-extended if_pc+1 (word index); always taken.
  - 0000111 HALT: no register write.
  - Any other opcode, funct3 or funct7 is illegal:
    - illegal pulses for 1 cycle (the cycle after EXEC);
    - no register write, no redirect;
    - returns to IDLE.
- Redirect target:
  - redirect_pc = pc + (sext(imm_b or imm_j) >>> 2). Offsets are in bytes; low 2 bits are dropped.
  - The addition wraps mod 2^PC_W.
- Writes to x0 are discarded.
- rs1/rs2 reads use register values from before the current instruction's write.
- Reset mid-EXEC or mid-FLUSH:
  - The in-flight write is lost.
  - Outputs return to their reset values immediately; no redirect is issued.
- if_valid deasserting while ex_ready=0 has no effect.
- Fetch must hold if_ir/if_pc stable until accepted.

Test Plan:
- Assert reset_n=0 mid-EXEC of ADDI x1,x0,5, then release -> ex_ready=1, redirect_valid=0, halted=0, dbg_data(x1)=0.
- Issue ADDI x1,x0,5 (0x00500093), ADDI x2,x0,-3 (0xFFD00113), ADD x3,x1,x2 (0x002081B3), SUB x4,x2,x1 (0x40110233) -> x3=0x2, x4=0xFFFFFFFFFFFFFFF8, one acceptance per 2 cycles.
- Issue LUI x5,0x80000 (0x800002B7) then ADDI x0,x0,7 (0x00700013) -> x5=0xFFFFFFFF80000000, x0 reads 0, illegal stays 0.
- Issue BEQ x0,x0,+8 (0x00000463) at if_pc=10 -> redirect_valid high exactly 1 cycle with redirect_pc=12, ex_ready=0 that cycle. Then BNE x0,x0,+8 (0x00001463) -> no redirect.
- Issue JAL x1,-4 (0xFFDFF0EF) at if_pc=20 -> redirect_pc=19, x1=21. Then 0xFFFFFFFF -> illegal pulses 1 cycle, no register changes, back to IDLE.
- Issue HALT (0x00000007) with if_valid held high -> halted=1, ex_ready=0 forever. Pulse reset_n low -> halted=0, ex_ready=1.

Source files
------------

// File: rtl/cpu_exec_stage.sv
// ==== cpu_exec_stage : decode/execute/write-back stage, 32 x XLEN register file ====
// ==== RV64I subset (LUI, ADDI, ADD/SUB, BEQ/BNE, JAL) plus board HALT. Rev 1.0  ====
`default_nettype none

module cpu_exec_stage #(
    parameter int XLEN = 64,
    parameter int PC_W = 32
) (
    input  logic            clock_1hz,
    input  logic            reset_n,
    input  logic            if_valid,
    input  logic [31:0]     if_ir,
    input  logic [PC_W-1:0] if_pc,
    output logic            ex_ready,
    output logic            redirect_valid,
    output logic [PC_W-1:0] redirect_pc,
    output logic            illegal,
    output logic            halted,
    input  logic [4:0]      dbg_sel,
    output logic [XLEN-1:0] dbg_data
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_HALT   = 7'b0000111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_FLUSH = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic [31:0]     ir_q;
    logic [PC_W-1:0] pc_q;
    logic [XLEN-1:0] regs [32];

    // Instruction fields of the latched word
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [6:0] funct7;

    assign opcode = ir_q[6:0];
    assign rd     = ir_q[11:7];
    assign funct3 = ir_q[14:12];
    assign rs1    = ir_q[19:15];
    assign rs2    = ir_q[24:20];
    assign funct7 = ir_q[31:25];

    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_u;
    logic [12:0]     imm_b;
    logic [20:0]     imm_j;
    logic [PC_W-1:0] off_b;
    logic [PC_W-1:0] off_j;

    assign rs1_val = regs[rs1];
    assign rs2_val = regs[rs2];
    assign imm_i   = {{(XLEN-12){ir_q[31]}}, ir_q[31:20]};
    assign imm_u   = {{(XLEN-32){ir_q[31]}}, ir_q[31:12], 12'h000};
    assign imm_b   = {ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j   = {ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // Byte offsets become word offsets: arithmetic shift by 2, then sign-extend
    assign off_b = {{(PC_W-11){imm_b[12]}}, imm_b[12:2]};
    assign off_j = {{(PC_W-19){imm_j[20]}}, imm_j[20:2]};

    logic            dec_wr_en;
    logic [XLEN-1:0] dec_wr_data;
    logic            dec_take;
    logic [PC_W-1:0] dec_target;
    logic            dec_halt;
    logic            dec_illegal;

    always_comb begin
        dec_wr_en   = 1'b0;
        dec_wr_data = '0;
        dec_take    = 1'b0;
        dec_target  = pc_q;
        dec_halt    = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec_wr_en   = 1'b1;
                dec_wr_data = imm_u;
            end
            OP_IMM: begin
                if (funct3 == 3'b000) begin
                    dec_wr_en   = 1'b1;
                    dec_wr_data = rs1_val + imm_i;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_REG: begin
                if (funct3 == 3'b000 && funct7 == 7'b0000000) begin
                    dec_wr_en   = 1'b1;
                    dec_wr_data = rs1_val + rs2_val;
                end else if (funct3 == 3'b000 && funct7 == 7'b0100000) begin
                    dec_wr_en   = 1'b1;
                    dec_wr_data = rs1_val - rs2_val;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                dec_target = pc_q + off_b;
                if (funct3 == 3'b000) begin
                    dec_take = (rs1_val == rs2_val);
                end else if (funct3 == 3'b001) begin
                    dec_take = (rs1_val != rs2_val);
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            OP_JAL: begin
                dec_wr_en   = 1'b1;
                dec_wr_data = {{(XLEN-PC_W){1'b0}}, pc_q + PC_W'(1)};
                dec_take    = 1'b1;
                dec_target  = pc_q + off_j;
            end
            OP_HALT: begin
                dec_halt = 1'b1;
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock_1hz or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (if_valid) next_state = S_EXEC;
            S_EXEC: begin
                if (dec_take) begin
                    next_state = S_FLUSH;
                end else if (dec_halt) begin
                    next_state = S_HALT;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_FLUSH: next_state = S_IDLE;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_IDLE;
        endcase
    end

    assign ex_ready = (state == S_IDLE);

    // Write-back happens on the edge leaving EXEC, so operands read old values
    always_ff @(posedge clock_1hz or negedge reset_n) begin
        if (!reset_n) begin
            ir_q           <= '0;
            pc_q           <= '0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            illegal        <= 1'b0;
            halted         <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (if_valid) begin
                        ir_q <= if_ir;
                        pc_q <= if_pc;
                    end
                end
                S_EXEC: begin
                    if (dec_wr_en && rd != 5'd0) begin
                        regs[rd] <= dec_wr_data;
                    end
                    if (dec_take) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= dec_target;
                    end
                    if (dec_halt) begin
                        halted <= 1'b1;
                    end
                    illegal <= dec_illegal;
                end
                S_FLUSH: begin
                    redirect_valid <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

    assign dbg_data = (dbg_sel == 5'd0) ? '0 : regs[dbg_sel];

endmodule

`default_nettype wire

// File: tb/tb_cpu_exec_stage.sv
// ==== tb_cpu_exec_stage : directed self-checking bench for cpu_exec_stage. Rev 1.0 ====
`default_nettype none

module tb_cpu_exec_stage;

    logic        clock_1hz;
    logic        reset_n;
    logic        if_valid;
    logic [31:0] if_ir;
    logic [31:0] if_pc;
    logic        ex_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal;
    logic        halted;
    logic [4:0]  dbg_sel;
    logic [63:0] dbg_data;

    int passed = 0;
    int total  = 0;

    cpu_exec_stage #(.XLEN(64), .PC_W(32)) dut (
        .clock_1hz      (clock_1hz),
        .reset_n        (reset_n),
        .if_valid       (if_valid),
        .if_ir          (if_ir),
        .if_pc          (if_pc),
        .ex_ready       (ex_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .illegal        (illegal),
        .halted         (halted),
        .dbg_sel        (dbg_sel),
        .dbg_data       (dbg_data)
    );

    initial clock_1hz = 1'b0;
    always #5 clock_1hz = ~clock_1hz;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic chk_reg(input string tag, input logic [4:0] idx, input logic [63:0] exp);
        dbg_sel = idx;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Caller sits on a negedge with the stage in IDLE; returns on the negedge in EXEC
    task automatic issue(input logic [31:0] ir, input logic [31:0] pc);
        if_valid = 1'b1;
        if_ir    = ir;
        if_pc    = pc;
        @(negedge clock_1hz);
        if_valid = 1'b0;
    endtask

    initial begin
        reset_n  = 1'b0;
        if_valid = 1'b0;
        if_ir    = '0;
        if_pc    = '0;
        dbg_sel  = '0;
        repeat (2) @(negedge clock_1hz);
        reset_n = 1'b1;

        // Reset landing in the middle of EXEC loses the write
        issue(32'h00500093, 32'd0);
        reset_n = 1'b0;
        @(negedge clock_1hz);
        reset_n = 1'b1;
        chk("rst_ex_ready", 64'(ex_ready), 64'd1);
        chk("rst_redirect", 64'(redirect_valid), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_illegal", 64'(illegal), 64'd0);
        chk_reg("rst_x1", 5'd1, 64'd0);
        @(negedge clock_1hz);

        // Arithmetic sequence
        issue(32'h00500093, 32'd1);
        chk("addi_busy", 64'(ex_ready), 64'd0);
        @(negedge clock_1hz);
        chk("addi_ready", 64'(ex_ready), 64'd1);
        issue(32'hFFD00113, 32'd2);
        @(negedge clock_1hz);
        issue(32'h002081B3, 32'd3);
        @(negedge clock_1hz);
        issue(32'h40110233, 32'd4);
        @(negedge clock_1hz);
        chk_reg("x1_5", 5'd1, 64'd5);
        chk_reg("x2_m3", 5'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        chk_reg("add_x3", 5'd3, 64'd2);
        chk_reg("sub_x4", 5'd4, 64'hFFFF_FFFF_FFFF_FFF8);
        @(negedge clock_1hz);

        // LUI sign extension and x0 write discard
        issue(32'h800002B7, 32'd5);
        @(negedge clock_1hz);
        issue(32'h00700013, 32'd6);
        @(negedge clock_1hz);
        chk("x0w_illegal", 64'(illegal), 64'd0);
        chk_reg("lui_x5", 5'd5, 64'hFFFF_FFFF_8000_0000);
        chk_reg("x0_zero", 5'd0, 64'd0);
        @(negedge clock_1hz);

        // Taken BEQ redirects for exactly one cycle
        issue(32'h00000463, 32'd10);
        @(negedge clock_1hz);
        chk("beq_rv", 64'(redirect_valid), 64'd1);
        chk("beq_rpc", 64'(redirect_pc), 64'd12);
        chk("beq_busy", 64'(ex_ready), 64'd0);
        @(negedge clock_1hz);
        chk("beq_rv_end", 64'(redirect_valid), 64'd0);
        chk("beq_ready", 64'(ex_ready), 64'd1);
        issue(32'h00001463, 32'd11);
        @(negedge clock_1hz);
        chk("bne_rv", 64'(redirect_valid), 64'd0);
        chk("bne_ready", 64'(ex_ready), 64'd1);

        // JAL with negative offset writes the link register
        issue(32'hFFDFF0EF, 32'd20);
        @(negedge clock_1hz);
        chk("jal_rv", 64'(redirect_valid), 64'd1);
        chk("jal_rpc", 64'(redirect_pc), 64'd19);
        chk_reg("jal_x1", 5'd1, 64'd21);
        @(negedge clock_1hz);
        chk("jal_rv_end", 64'(redirect_valid), 64'd0);

        // Unsupported opcode
        issue(32'hFFFFFFFF, 32'd19);
        @(negedge clock_1hz);
        chk("ill_pulse", 64'(illegal), 64'd1);
        chk("ill_rv", 64'(redirect_valid), 64'd0);
        chk_reg("ill_x1", 5'd1, 64'd21);
        chk_reg("ill_x31", 5'd31, 64'd0);
        @(negedge clock_1hz);
        chk("ill_end", 64'(illegal), 64'd0);
        chk("ill_ready", 64'(ex_ready), 64'd1);

        // HALT with fetch still presenting words
        if_valid = 1'b1;
        if_ir    = 32'h00000007;
        if_pc    = 32'd30;
        @(negedge clock_1hz);
        @(negedge clock_1hz);
        chk("halt_set", 64'(halted), 64'd1);
        chk("halt_busy", 64'(ex_ready), 64'd0);
        repeat (5) @(negedge clock_1hz);
        chk("halt_sticky", 64'(halted), 64'd1);
        chk("halt_busy2", 64'(ex_ready), 64'd0);
        reset_n = 1'b0;
        @(negedge clock_1hz);
        if_valid = 1'b0;
        reset_n  = 1'b1;
        chk("hrst_halted", 64'(halted), 64'd0);
        chk("hrst_ready", 64'(ex_ready), 64'd1);
        chk_reg("hrst_x5", 5'd5, 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
